// File: rtl/system_reset_ctrl.sv
// Reset sequencer: merges watchdog, debug and keyed software reset requests, holds all
// domains in reset, then releases them in staggered order. Cause/count behind Avalon-MM.
module system_reset_ctrl #(
    parameter int          NUM_DOMAINS    = 3,
    parameter int          HOLD_CYCLES    = 16,
    parameter int          STAGGER_CYCLES = 4,
    parameter logic [7:0]  SW_KEY         = 8'hA5
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wdt_resetrequest,
    input  logic                   dbg_resetrequest,
    input  logic [1:0]             address,
    input  logic                   chipselect,
    input  logic                   write_n,
    input  logic [15:0]            writedata,
    output logic [15:0]            readdata,
    output logic [NUM_DOMAINS-1:0] reset_out_n,
    output logic                   reset_active
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int STG_W  = $clog2(STAGGER_CYCLES + 1);
    localparam int IDX_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STG_W-1:0]  STG_LOAD  = STG_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [STG_W-1:0]  stg_cnt;
    logic [IDX_W-1:0]  idx;
    logic              dbg_meta;
    logic              dbg_sync;
    logic [3:0]        cause;
    logic [7:0]        count;
    logic [15:0]       rd_mux;

    logic bus_wr;
    logic sw_req;
    logic req;
    logic entry;
    logic cause_wr;
    logic count_wr;

    assign bus_wr   = chipselect & ~write_n;
    assign sw_req   = bus_wr && (address == 2'd1) && (writedata[7:0] == SW_KEY);
    assign req      = wdt_resetrequest | dbg_sync | sw_req;
    assign entry    = req && (state != ST_ASSERT);
    assign cause_wr = bus_wr && (address == 2'd0);
    assign count_wr = bus_wr && (address == 2'd2);

    // Debug request arrives from another clock domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dbg_meta <= 1'b0;
            dbg_sync <= 1'b0;
        end else begin
            dbg_meta <= dbg_resetrequest;
            dbg_sync <= dbg_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_ASSERT;
            hold_cnt     <= HOLD_LOAD;
            stg_cnt      <= '0;
            idx          <= '0;
            reset_out_n  <= '0;
            reset_active <= 1'b1;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (req) begin
                        hold_cnt <= HOLD_LOAD;
                    end else if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end else begin
                        reset_out_n[0] <= 1'b1;
                        if (NUM_DOMAINS == 1) begin
                            state        <= ST_RUN;
                            reset_active <= 1'b0;
                        end else begin
                            state   <= ST_RELEASE;
                            idx     <= IDX_W'(1);
                            stg_cnt <= STG_LOAD;
                        end
                    end
                end
                ST_RUN, ST_RELEASE: begin
                    if (req) begin
                        state        <= ST_ASSERT;
                        reset_active <= 1'b1;
                        reset_out_n  <= '0;
                        hold_cnt     <= HOLD_LOAD;
                    end else if (state == ST_RELEASE) begin
                        if (stg_cnt != '0) begin
                            stg_cnt <= stg_cnt - STG_W'(1);
                        end else begin
                            reset_out_n[idx] <= 1'b1;
                            if (idx == LAST_IDX) begin
                                state        <= ST_RUN;
                                reset_active <= 1'b0;
                            end else begin
                                idx     <= idx + IDX_W'(1);
                                stg_cnt <= STG_LOAD;
                            end
                        end
                    end
                end
                // Unreachable encoding: fall back into a full reset sequence.
                default: begin
                    state        <= ST_ASSERT;
                    reset_active <= 1'b1;
                    reset_out_n  <= '0;
                    hold_cnt     <= HOLD_LOAD;
                end
            endcase
        end
    end

    // A source setting its cause bit on the same edge as a W1C clear keeps the bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cause <= 4'b0001;
            count <= 8'd0;
        end else begin
            cause <= (cause & ~(cause_wr ? writedata[3:0] : 4'b0000))
                   | {sw_req, dbg_sync, wdt_resetrequest, 1'b0};
            if (count_wr)
                count <= entry ? 8'd1 : 8'd0;
            else if (entry && (count != 8'hFF))
                count <= count + 8'd1;
        end
    end

    always_comb begin
        rd_mux = 16'h0000;
        case (address)
            2'd0: rd_mux = {12'h000, cause};
            2'd2: rd_mux = {8'h00, count};
            2'd3: rd_mux = {8'(reset_out_n), 6'b000000, state};
            default: rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata <= 16'h0000;
        else
            readdata <= rd_mux;
    end

endmodule

// File: tb/tb_system_reset_ctrl.sv
// Bench for system_reset_ctrl: register reads go through a scoreboard queue, reset
// output sequences are checked edge by edge against the hold/stagger timing.
module tb_system_reset_ctrl;

    localparam int ND   = 3;
    localparam int HOLD = 16;
    localparam int STAG = 4;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b1;
    logic          wdt       = 1'b0;
    logic          dbg       = 1'b0;
    logic          cs        = 1'b0;
    logic          write_n   = 1'b1;
    logic [1:0]    address   = 2'd0;
    logic [15:0]   writedata = 16'h0000;
    logic [15:0]   readdata;
    logic [ND-1:0] reset_out_n;
    logic          reset_active;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];
    string       tag_q[$];
    logic        rd_valid = 1'b0;

    always #5 clk = ~clk;

    system_reset_ctrl #(
        .NUM_DOMAINS   (ND),
        .HOLD_CYCLES   (HOLD),
        .STAGGER_CYCLES(STAG),
        .SW_KEY        (8'hA5)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .wdt_resetrequest(wdt),
        .dbg_resetrequest(dbg),
        .address         (address),
        .chipselect      (cs),
        .write_n         (write_n),
        .writedata       (writedata),
        .readdata        (readdata),
        .reset_out_n     (reset_out_n),
        .reset_active    (reset_active)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return 16'({reset_active, reset_out_n});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: a read issued on edge r is compared at the following negedge.
    always @(posedge clk) rd_valid <= cs && write_n && reset_n;

    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0)
                check("sb_empty", 16'(exp_q.size()), 16'd1);
            else
                check(tag_q.pop_front(), readdata, exp_q.pop_front());
        end
    end

    task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string tag);
        cs      = 1'b1;
        write_n = 1'b1;
        address = a;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        tick();
        cs = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        cs        = 1'b1;
        write_n   = 1'b0;
        address   = a;
        writedata = d;
        tick();
        cs        = 1'b0;
        write_n   = 1'b1;
        writedata = 16'h0000;
    endtask

    // Called just after the last edge with req high; domain k rises HOLD+k*STAG edges later.
    task automatic watch_seq(input string tag);
        logic [ND-1:0] exp_o;
        logic          exp_act;
        for (int n = 1; n <= HOLD + (ND - 1) * STAG + 1; n++) begin
            tick();
            exp_o = '0;
            for (int k = 0; k < ND; k++)
                if (n >= HOLD + k * STAG) exp_o[k] = 1'b1;
            exp_act = (n < HOLD + (ND - 1) * STAG);
            check(tag, outs(), 16'({exp_act, exp_o}));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", 16'(reset_out_n), 16'h0000);
        check("rst_active", 16'(reset_active), 16'h0001);
        check("rst_rdata", readdata, 16'h0000);

        // Power-on sequence
        reset_n = 1'b1;
        watch_seq("t1_seq");
        rd(2'd3, 16'h0700, "t1_status");
        rd(2'd0, 16'h0001, "t1_cause");
        rd(2'd2, 16'h0000, "t1_count");

        // Watchdog request held for two edges
        wdt = 1'b1;
        tick();
        check("t2_assert", outs(), 16'h0008);
        tick();
        wdt = 1'b0;
        watch_seq("t2_seq");
        rd(2'd0, 16'h0003, "t2_cause");
        rd(2'd2, 16'h0001, "t2_count");
        wr(2'd0, 16'h000F);
        rd(2'd0, 16'h0000, "t2_cause_clr");

        // Software key
        wr(2'd1, 16'h00A5);
        watch_seq("t3_seq");
        rd(2'd0, 16'h0008, "t3_cause");
        rd(2'd2, 16'h0002, "t3_count");
        wr(2'd1, 16'h005A);
        tick();
        tick();
        check("t3_nokey", outs(), 16'h0007);
        rd(2'd1, 16'h0000, "t3_ctrl_rd");
        rd(2'd2, 16'h0002, "t3_count_nokey");
        rd(2'd0, 16'h0008, "t3_cause_nokey");
        wr(2'd0, 16'h000F);

        // Debug pulse during release, after domain 0 is up
        wdt = 1'b1;
        tick();
        wdt = 1'b0;
        repeat (HOLD + 1) tick();
        check("t4_pre", outs(), 16'h0009);
        dbg = 1'b1;
        tick();
        dbg = 1'b0;
        check("t4_sync1", outs(), 16'h0009);
        tick();
        check("t4_sync2", outs(), 16'h0009);
        tick();
        check("t4_hit", outs(), 16'h0008);
        watch_seq("t4_seq");
        rd(2'd2, 16'h0004, "t4_count");
        rd(2'd0, 16'h0006, "t4_cause");

        // W1C clear on the same edge as a watchdog set
        wdt = 1'b1;
        wr(2'd0, 16'h000F);
        wdt = 1'b0;
        rd(2'd0, 16'h0002, "t5_cause_w1c");
        repeat (HOLD + (ND - 1) * STAG + 2) tick();
        check("t5_idle", outs(), 16'h0007);
        rd(2'd2, 16'h0005, "t5_count");

        // COUNT write and increment on the same edge
        wdt = 1'b1;
        wr(2'd2, 16'h0000);
        wdt = 1'b0;
        rd(2'd2, 16'h0001, "t5_count_wr_inc");
        repeat (HOLD - 1) tick();

        // Saturation: each pulse lands in RELEASE and is a new entry
        for (int i = 0; i < 300; i++) begin
            wdt = 1'b1;
            tick();
            wdt = 1'b0;
            repeat (HOLD) tick();
        end
        rd(2'd2, 16'h00FF, "t5_count_sat");
        repeat (HOLD + (ND - 1) * STAG + 2) tick();
        check("t5_idle2", outs(), 16'h0007);
        wr(2'd2, 16'h1234);
        rd(2'd2, 16'h0000, "t5_count_clr");

        repeat (2) tick();
        check("sb_drain", 16'(exp_q.size()), 16'h0000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
